// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch answered after LATENCY cycles, plus a backdoor word loader.
// Define IMEM_BYTE_SWAP_EN to byte-reverse fetched words (little-endian load image feeding a big-endian core).
module imem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read,
   input  logic [31:0] addr,
   output logic        waitrequest,
   output logic        readdatavalid,
   output logic [31:0] instruction_word,
   output logic        fetch_err,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);
   localparam int          IW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic        accept;
   logic [31:0] data_q;
   logic        err_q;
   logic [31:0] word_out;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_off, ld_off;
   logic        rd_bad, ld_ok;
   logic [31:0] rd_word;

   // Wrap-around offsets: addresses below BASE_ADDR become huge and fall out of range.
   assign rd_off  = addr - BASE_ADDR;
   assign ld_off  = load_addr - BASE_ADDR;
   assign rd_bad  = (addr[1:0] != 2'b00) || (addr == 32'h0) || (rd_off >= SPAN);
   assign ld_ok   = (load_addr[1:0] == 2'b00) && (ld_off < SPAN);
   assign rd_word = mem[rd_off[IW+1:2]];

   // No reset: image survives reset; a same-edge load is seen only by later fetches.
   always_ff @(posedge clk) begin
      if (load_en && ld_ok)
         mem[ld_off[IW+1:2]] <= load_data;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (read) begin
               accept    = 1'b1;
               cnt_nxt   = 3'(LATENCY - 1);
               state_nxt = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1)
               state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= 3'd0;
         data_q <= 32'h0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            data_q <= rd_bad ? 32'h0 : rd_word;
            err_q  <= rd_bad;
         end
      end
   end

`ifdef IMEM_BYTE_SWAP_EN
   assign word_out = {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};
`else
   assign word_out = data_q;
`endif

   assign waitrequest      = (state != IDLE);
   assign readdatavalid    = (state == RESP);
   assign fetch_err        = readdatavalid & err_q;
   assign instruction_word = readdatavalid ? word_out : 32'h0;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a cycle-level handshake model queues expected fetch results.
module tb_imem_responder;
   localparam logic [31:0] BASE  = 32'hBFC00000;
   localparam int          DEPTH = 16;
   localparam int          LAT   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        read = 1'b0;
   logic [31:0] addr = 32'h0;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = 32'h0;
   logic [31:0] load_data = 32'h0;
   logic        waitrequest, readdatavalid, fetch_err;
   logic [31:0] instruction_word;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mmem [DEPTH];
   logic [32:0] expq [$];
   int          busy = 0;

   always #5 clk = ~clk;

   imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .read(read), .addr(addr),
      .waitrequest(waitrequest), .readdatavalid(readdatavalid),
      .instruction_word(instruction_word), .fetch_err(fetch_err),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, act, req);
      end
   endtask

   function automatic bit in_span(input logic [31:0] a);
      logic [31:0] d;
      d = a - BASE;
      return (a[1:0] == 2'b00) && (d < 32'(DEPTH * 4));
   endfunction

   function automatic int widx(input logic [31:0] a);
      logic [31:0] d;
      d = (a - BASE) >> 2;
      return int'(d);
   endfunction

   function automatic logic [31:0] present(input logic [31:0] w);
`ifdef IMEM_BYTE_SWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic logic [31:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0:       return 32'h0;
         1:       return BASE + 32'($urandom_range(0, DEPTH * 4 + 8));
         2:       return $urandom;
         3:       return BASE - 32'd4;
         default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
   endfunction

   // Reference: a fetch occupies the responder for LAT cycles after acceptance, the result
   // appears in the last of them, and the word is whatever memory held before this edge's load.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy = 0;
         expq.delete();
      end else begin
         if (busy == 0) begin
            if (read) begin
               if (in_span(addr) && addr != 32'h0)
                  expq.push_back({1'b0, present(mmem[widx(addr)])});
               else
                  expq.push_back({1'b1, 32'h0});
               busy = LAT;
            end
         end else begin
            busy--;
         end
         if (load_en && in_span(load_addr))
            mmem[widx(load_addr)] = load_data;
      end
   end

   always @(negedge clk) begin
      logic [32:0] e;
      if (reset) begin
         chk("waitrequest", 64'(waitrequest), 64'(busy != 0));
         chk("rdv_timing", 64'(readdatavalid), 64'(busy == 1));
         if (readdatavalid) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rdv actual=1 required=0");
            end else begin
               e = expq.pop_front();
               chk("instruction_word", 64'(instruction_word), 64'(e[31:0]));
               chk("fetch_err", 64'(fetch_err), 64'(e[32]));
            end
         end else begin
            chk("idle_zero", {31'h0, fetch_err, instruction_word}, 64'h0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      cyc();
      load_en = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a);
      read = 1'b1; addr = a;
      cyc();
      read = 1'b0;
      repeat (LAT + 1) cyc();
   endtask

   task automatic reset_pulse(input string n);
      read = 1'b0; load_en = 1'b0;
      reset = 1'b0;
      #1;
      chk(n, {29'h0, waitrequest, readdatavalid, fetch_err, instruction_word}, 64'h0);
      @(negedge clk);
      #2 reset = 1'b1;
      cyc();
   endtask

   initial begin
      #1 reset = 1'b0;
      #1;
      chk("reset_state", {29'h0, waitrequest, readdatavalid, fetch_err, instruction_word}, 64'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < DEPTH; i++) do_load(BASE + 32'(4 * i), $urandom);

      do_load(BASE, 32'h3C011234);
      do_read(BASE);
      do_read(BASE + 32'd2);
      do_read(32'h0);
      do_read(BASE + 32'(DEPTH * 4));

      read = 1'b1; addr = BASE + 32'd8;
      repeat (10) cyc();
      read = 1'b0;
      repeat (LAT + 1) cyc();

      do_load(BASE + 32'd4, 32'h11111111);
      read = 1'b1; addr = BASE + 32'd4;
      load_en = 1'b1; load_addr = BASE + 32'd4; load_data = 32'h22222222;
      cyc();
      read = 1'b0; load_en = 1'b0;
      repeat (LAT + 1) cyc();
      do_read(BASE + 32'd4);

      read = 1'b1; addr = BASE;
      cyc();
      read = 1'b0;
      @(posedge clk);
      #2;
      reset_pulse("reset_abort");
      repeat (LAT + 1) cyc();
      do_read(BASE);

      do_load(BASE + 32'd12, 32'h0C000010);
      do_read(BASE + 32'd12);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset_pulse("reset_random");
         end else begin
            read      = ($urandom_range(0, 1) == 1);
            addr      = pick_addr();
            load_en   = ($urandom_range(0, 9) < 3);
            load_addr = pick_addr();
            load_data = $urandom;
            cyc();
         end
      end
      read = 1'b0; load_en = 1'b0;
      repeat (LAT + 3) cyc();
      chk("drain", 64'(expq.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
